// File: rtl/addsub_seq_pkg.sv
// Shared types and helpers for the multi-word add/subtract sequencer.
// Holds the control FSM state encoding and the signed-overflow rule.
package addsub_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Overflow occurs when both effective operands share a sign and the result does not.
   function automatic logic calc_ovf(input logic a_msb,
                                     input logic b_msb,
                                     input logic sub,
                                     input logic g_msb);
      logic beff_msb;
      beff_msb = b_msb ^ sub;
      return (a_msb == beff_msb) && (g_msb != a_msb);
   endfunction

endpackage

// File: rtl/adder_subtractor_rc.sv
// WIDTH-bit ripple-carry adder/subtractor: {co,g} = a + (sub ? ~b : b) + ci.
// Purely combinational; used as the shared per-word datapath.
module adder_subtractor_rc #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             ci,
   output logic [WIDTH-1:0] g,
   output logic             co
);

   logic [WIDTH:0]   w_c;
   logic [WIDTH-1:0] w_beff;

   assign w_c[0] = ci;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign w_beff[gi]  = b[gi] ^ sub;
         assign g[gi]       = a[gi] ^ w_beff[gi] ^ w_c[gi];
         assign w_c[gi + 1] = (a[gi] & w_beff[gi]) | (w_c[gi] & (a[gi] ^ w_beff[gi]));
      end
   endgenerate

   assign co = w_c[WIDTH];

endmodule

// File: rtl/multiword_addsub_seq.sv
// Multi-precision add/subtract: one WIDTH-bit word per clock through a single
// shared ripple-carry unit, LSW first, carry chained through a register.
module multiword_addsub_seq
   import addsub_seq_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int WORDS = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   sub,
   input  logic [WIDTH*WORDS-1:0] a,
   input  logic [WIDTH*WORDS-1:0] b,
   output logic                   busy,
   output logic                   done,
   output logic [WIDTH*WORDS-1:0] g,
   output logic                   co,
   output logic                   ovf
);

   localparam int N  = WIDTH * WORDS;
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

   state_t          r_state;
   state_t          w_state_next;
   logic [N-1:0]    r_a;
   logic [N-1:0]    r_b;
   logic [N-1:0]    r_g;
   logic            r_sub;
   logic            r_carry;
   logic            r_co;
   logic            r_ovf;
   logic [IW-1:0]   r_idx;

   logic [WIDTH-1:0] w_a_word;
   logic [WIDTH-1:0] w_b_word;
   logic [WIDTH-1:0] w_g_word;
   logic             w_co_word;
   logic             w_last;
   logic             w_accept;

   assign w_a_word = r_a[r_idx*WIDTH +: WIDTH];
   assign w_b_word = r_b[r_idx*WIDTH +: WIDTH];
   assign w_last   = (r_idx == IW'(WORDS - 1));
   assign w_accept = (r_state == IDLE) && start;

   adder_subtractor_rc #(.WIDTH(WIDTH)) u_addsub (
      .a   (w_a_word),
      .b   (w_b_word),
      .sub (r_sub),
      .ci  (r_carry),
      .g   (w_g_word),
      .co  (w_co_word)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = RUN;
         RUN:     if (w_last) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a     <= '0;
         r_b     <= '0;
         r_g     <= '0;
         r_sub   <= 1'b0;
         r_carry <= 1'b0;
         r_co    <= 1'b0;
         r_ovf   <= 1'b0;
         r_idx   <= '0;
      end else if (w_accept) begin
         r_a     <= a;
         r_b     <= b;
         r_sub   <= sub;
         r_carry <= sub;
         r_g     <= '0;
         r_co    <= 1'b0;
         r_ovf   <= 1'b0;
         r_idx   <= '0;
      end else if (r_state == RUN) begin
         r_g[r_idx*WIDTH +: WIDTH] <= w_g_word;
         r_carry                   <= w_co_word;
         r_idx                     <= r_idx + 1'b1;
         // Flags are captured with the last word so they are valid during DONE.
         if (w_last) begin
            r_co  <= w_co_word;
            r_ovf <= calc_ovf(r_a[N-1], r_b[N-1], r_sub, w_g_word[WIDTH-1]);
            r_idx <= '0;
         end
      end
   end

   assign busy = (r_state != IDLE);
   assign done = (r_state == DONE);
   assign g    = r_g;
   assign co   = r_co;
   assign ovf  = r_ovf;

endmodule
